// File: rtl/spi_bus_arbiter.sv
// Arbitrates one shared SPI pad set between the flash and PSRAM controllers.
// Round-robin on ties, guard gap between owners, optional hold timeout.
//
// state     | meaning
// IDLE      | no owner; eligible requests are evaluated here only
// OWN_FLASH | flash controller drives the pads
// OWN_RAM   | RAM controller drives the pads
// GUARD     | both CS_N forced high for GUARD_CYCLES before the next grant
module spi_bus_arbiter #(
    parameter int GUARD_CYCLES = 2,
    parameter int MAX_HOLD     = 4096,
    parameter int HOLD_W       = 13
) (
    input  logic clk,
    input  logic resetn,
    input  logic req_flash,
    output logic gnt_flash,
    input  logic flash_clk,
    input  logic flash_cs_n,
    input  logic flash_mosi,
    output logic flash_miso,
    input  logic req_ram,
    output logic gnt_ram,
    input  logic ram_clk,
    input  logic ram_cs_n,
    input  logic ram_mosi,
    output logic ram_miso,
    output logic spi_clk,
    output logic spi_mosi,
    input  logic spi_miso,
    output logic spi_cs_n_flash,
    output logic spi_cs_n_ram,
    output logic busy,
    output logic timeout
);

    localparam int GUARD_W = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam logic [GUARD_W-1:0] GUARD_LOAD = GUARD_W'(GUARD_CYCLES - 1);
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
    localparam bit HOLD_EN = (MAX_HOLD != 0);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        OWN_FLASH = 2'd1,
        OWN_RAM   = 2'd2,
        GUARD     = 2'd3
    } state_t;

    state_t              state, state_next;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [GUARD_W-1:0]  guard_cnt;
    logic                last_ram;
    logic                blocked_flash, blocked_ram;
    logic                elig_flash, elig_ram;
    logic                timeout_next;
    logic                block_flash_set, block_ram_set;

    assign elig_flash = req_flash & ~blocked_flash;
    assign elig_ram   = req_ram & ~blocked_ram;

    always_comb begin
        state_next      = state;
        timeout_next    = 1'b0;
        block_flash_set = 1'b0;
        block_ram_set   = 1'b0;
        case (state)
            IDLE: begin
                if (elig_flash && elig_ram)
                    state_next = last_ram ? OWN_FLASH : OWN_RAM;
                else if (elig_flash)
                    state_next = OWN_FLASH;
                else if (elig_ram)
                    state_next = OWN_RAM;
            end
            OWN_FLASH: begin
                // a release on the same cycle as expiry wins over the timeout
                if (!req_flash) begin
                    state_next = GUARD;
                end else if (HOLD_EN && hold_cnt == HOLD_LAST) begin
                    state_next      = GUARD;
                    timeout_next    = 1'b1;
                    block_flash_set = 1'b1;
                end
            end
            OWN_RAM: begin
                if (!req_ram) begin
                    state_next = GUARD;
                end else if (HOLD_EN && hold_cnt == HOLD_LAST) begin
                    state_next    = GUARD;
                    timeout_next  = 1'b1;
                    block_ram_set = 1'b1;
                end
            end
            GUARD: begin
                if (guard_cnt == '0)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= IDLE;
            gnt_flash     <= 1'b0;
            gnt_ram       <= 1'b0;
            timeout       <= 1'b0;
            hold_cnt      <= '0;
            guard_cnt     <= '0;
            last_ram      <= 1'b1;
            blocked_flash <= 1'b0;
            blocked_ram   <= 1'b0;
        end else begin
            state     <= state_next;
            gnt_flash <= (state_next == OWN_FLASH);
            gnt_ram   <= (state_next == OWN_RAM);
            timeout   <= timeout_next;

            if (state == OWN_FLASH || state == OWN_RAM)
                hold_cnt <= hold_cnt + 1'b1;
            else
                hold_cnt <= '0;

            if (state != GUARD)
                guard_cnt <= GUARD_LOAD;
            else if (guard_cnt != '0)
                guard_cnt <= guard_cnt - 1'b1;

            if (state == IDLE && state_next == OWN_FLASH)
                last_ram <= 1'b0;
            else if (state == IDLE && state_next == OWN_RAM)
                last_ram <= 1'b1;

            if (block_flash_set)
                blocked_flash <= 1'b1;
            else if (!req_flash)
                blocked_flash <= 1'b0;

            if (block_ram_set)
                blocked_ram <= 1'b1;
            else if (!req_ram)
                blocked_ram <= 1'b0;
        end
    end

    // Pads follow the registered grants, so a reset clears them asynchronously.
    always_comb begin
        spi_clk        = 1'b0;
        spi_mosi       = 1'b0;
        spi_cs_n_flash = 1'b1;
        spi_cs_n_ram   = 1'b1;
        flash_miso     = 1'b0;
        ram_miso       = 1'b0;
        if (gnt_flash) begin
            spi_clk        = flash_clk;
            spi_mosi       = flash_mosi;
            spi_cs_n_flash = flash_cs_n;
            flash_miso     = spi_miso;
        end else if (gnt_ram) begin
            spi_clk      = ram_clk;
            spi_mosi     = ram_mosi;
            spi_cs_n_ram = ram_cs_n;
            ram_miso     = spi_miso;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: doc/spi_bus_arbiter.md
Name: spi_bus_arbiter

Overview:
- Shares one physical SPI bus (SCK, MOSI, MISO) between the memory-mapped flash controller and the memory-mapped SPI RAM controller. Each device keeps its own chip select.
- Each controller raises a request and waits for a grant before it drives any SPI pin. The arbiter then routes that controller's CLK/CS_N/MOSI to the pads and routes the pad MISO back to it.
- Sits between the two mapped SPI controllers and the top-level pads, so flash and PSRAM can share pins.

Parameters:
- GUARD_CYCLES, 2, idle cycles with both CS_N high between consecutive grants (minimum 1).
- MAX_HOLD, 4096, maximum clk cycles a single grant may last. 0 disables the timeout.
- HOLD_W, 13, width of the hold counter. Must satisfy 2^HOLD_W > MAX_HOLD.

Ports:
- clk  input  1  system clock
- resetn  input  1  asynchronous active-low reset
- req_flash  input  1  flash controller requests the bus
- gnt_flash  output  1  flash controller owns the bus
- flash_clk  input  1  flash controller SCK
- flash_cs_n  input  1  flash controller chip select
- flash_mosi  input  1  flash controller MOSI
- flash_miso  output  1  MISO returned to flash controller
- req_ram  input  1  RAM controller requests the bus
- gnt_ram  output  1  RAM controller owns the bus
- ram_clk  input  1  RAM controller SCK
- ram_cs_n  input  1  RAM controller chip select
- ram_mosi  input  1  RAM controller MOSI
- ram_miso  output  1  MISO returned to RAM controller
- spi_clk  output  1  shared pad SCK
- spi_mosi  output  1  shared pad MOSI
- spi_miso  input  1  shared pad MISO
- spi_cs_n_flash  output  1  flash pad chip select
- spi_cs_n_ram  output  1  PSRAM pad chip select
- busy  output  1  high whenever state is not IDLE
- timeout  output  1  one-cycle pulse when a grant is forcibly revoked

Behaviour:
- Reset is asynchronous on the falling edge of resetn. Every register takes its reset value immediately:
  - state=IDLE, gnt_flash=0, gnt_ram=0, timeout=0, hold counter=0, guard counter=0.
  - last_owner=RAM, so flash wins the first tie.
  - blocked_flash=0, blocked_ram=0.
- Combinational outputs during reset: spi_clk=0, spi_mosi=0, spi_cs_n_flash=1, spi_cs_n_ram=1, flash_miso=0, ram_miso=0, busy=0.
- Pad muxing is combinational, driven from the registered grants:
  - gnt_flash=1: spi_clk=flash_clk, spi_mosi=flash_mosi, spi_cs_n_flash=flash_cs_n, flash_miso=spi_miso.
  - gnt_ram=1: the same mapping using the ram_* signals and spi_cs_n_ram.
  - The non-granted CS_N is forced to 1 and the non-granted *_miso is forced to 0.
  - No grant: spi_clk=0, spi_mosi=0, both CS_N=1.
- gnt_flash and gnt_ram are never both 1.
- States: IDLE, OWN_FLASH, OWN_RAM, GUARD.
- IDLE:
  - An eligible request is req_x=1 with blocked_x=0.
  - One eligible request: go to OWN_x and set gnt_x=1 on the next edge (grant latency 1 cycle).
  - Both eligible: grant the requester that is not last_owner (round robin).
  - No eligible request: stay in IDLE.
- OWN_x:
  - On entry: hold counter=0, last_owner=x. The counter increments every cycle while in OWN_x.
  - If req_x=0 when sampled: gnt_x=0 on the next edge, then GUARD. The requester must already have its cs_n high; the arbiter forces the pad CS_N high regardless once gnt drops.
  - If MAX_HOLD≠0 and the hold counter reaches MAX_HOLD-1 while req_x=1: gnt_x=0, timeout=1 for exactly one cycle, blocked_x=1, then GUARD.
  - A simultaneous req drop and timeout counts as a normal release: no timeout pulse and no block.
- GUARD:
  - Guard counter loads GUARD_CYCLES-1 and counts down. Both CS_N stay high and no grant is given.
  - Return to IDLE after exactly GUARD_CYCLES cycles.
  - Requests arriving during GUARD are evaluated only in IDLE.
- blocked_x clears on any cycle where req_x=0. A timed-out requester must drop req for at least one cycle before it can be granted again.
- A request that drops in IDLE before being granted is simply not granted; there is no latching.
- resetn asserted mid-transfer: all grants drop asynchronously and both CS_N go high immediately. Controllers are reset by the same resetn.

Test Plan:
- Reset: hold resetn=0 with req_flash=req_ram=1 -> gnt both 0, spi_cs_n_flash=spi_cs_n_ram=1, spi_clk=0, busy=0.
- Single request: req_flash rises at cycle 0 -> gnt_flash=1 at cycle 1. Toggle flash_clk/flash_mosi -> pads mirror them with zero latency. spi_miso=1 -> flash_miso=1 and ram_miso=0.
- Tie and round robin: after reset, req_flash=req_ram=1 together -> flash granted first. Flash drops req -> gnt_flash=0 next edge, then 2 GUARD cycles with both CS_N=1, then gnt_ram=1.
- Fairness: both requesters re-request continuously for 6 transactions -> grants alternate F,R,F,R,F,R. The two grants never overlap and there are always ≥2 guard cycles between them.
- Timeout: MAX_HOLD=16, req_ram held high -> after 16 cycles of gnt_ram=1 the grant drops and timeout pulses for 1 cycle. RAM is not re-granted while req_ram stays high. After req_ram is low for 1 cycle and rises again, it is re-granted (once past GUARD).
- Mid-transfer reset: resetn=0 while gnt_ram=1 and ram_cs_n=0 -> spi_cs_n_ram=1 and gnt_ram=0 before the next clk edge.
